// File: rtl/seg7_capture.sv
// Purpose : receive-side monitor for a multiplexed 4-digit active-low 7-segment bus; decodes digits into frames.
// Latency : a bus value held from cycle t commits at edge t+1+STABLE_CYCLES; the frame pulse follows one cycle later.
// Backpress: none -- passive observer; frames are overwritten in place and the consumer must sample on FRAME_VALID_OUT.
module seg7_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  SEG_SELECT_IN,
    input  logic [7:0]  HEX_IN,
    output logic [15:0] VALUE_OUT,
    output logic [3:0]  DOTS_OUT,
    output logic        FRAME_VALID_OUT,
    output logic [3:0]  DIGIT_ERR_OUT,
    output logic        STALE_OUT
);

    localparam logic [7:0]  STABLE_W = 8'(STABLE_CYCLES);
    localparam logic [23:0] TMO_W    = 24'(TIMEOUT_CYCLES);

    // Returns {err, nibble}; segment order is g..a in bits 6..0, active-low.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h18:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [3:0]  sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic [7:0]  hex_s1_q, hex_s1_d, hex_s2_q, hex_s2_d;
    logic [11:0] smp_prev_q, smp_prev_d;
    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic [15:0] shadow_val_q, shadow_val_d;
    logic [3:0]  shadow_dot_q, shadow_dot_d;
    logic [3:0]  shadow_err_q, shadow_err_d;
    logic [3:0]  captured_q, captured_d;
    logic [23:0] tmo_cnt_q, tmo_cnt_d;
    logic        stale_q, stale_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  dots_q, dots_d;
    logic [3:0]  err_q, err_d;
    logic        frame_vld_q, frame_vld_d;

    logic        legal;
    logic        same;
    logic        commit;
    logic        frame_done;
    logic [1:0]  dig_idx;
    logic [4:0]  dec;

    // Next-state: synchroniser, stability tracking, digit commit, frame publish and timeout.
    always_comb begin
        sel_s1_d     = SEG_SELECT_IN;
        hex_s1_d     = HEX_IN;
        sel_s2_d     = sel_s1_q;
        hex_s2_d     = hex_s1_q;
        smp_prev_d   = {sel_s2_q, hex_s2_q};
        shadow_val_d = shadow_val_q;
        shadow_dot_d = shadow_dot_q;
        shadow_err_d = shadow_err_q;
        value_d      = value_q;
        dots_d       = dots_q;
        err_d        = err_q;
        stale_d      = stale_q;
        tmo_cnt_d    = tmo_cnt_q;

        legal   = 1'b1;
        dig_idx = 2'd0;
        case (sel_s2_q)
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: legal   = 1'b0;
        endcase

        same = ({sel_s2_q, hex_s2_q} == smp_prev_q);

        if (!legal) begin
            stab_cnt_d = 8'd0;
        end else if (same) begin
            stab_cnt_d = (stab_cnt_q == STABLE_W) ? stab_cnt_q : stab_cnt_q + 8'd1;
        end else begin
            stab_cnt_d = 8'd1;
        end

        // A saturated counter holding an unchanged value must not fire again;
        // a fresh value reaching the threshold (even at STABLE_CYCLES=1) must.
        commit = legal && (stab_cnt_d == STABLE_W) && !(same && (stab_cnt_q == STABLE_W));
        dec    = decode_seg(hex_s2_q[6:0]);

        // Publish the shadow the cycle after the last missing digit lands.
        frame_done  = (captured_q == 4'hF);
        frame_vld_d = frame_done;
        captured_d  = frame_done ? 4'h0 : captured_q;
        if (frame_done) begin
            value_d = shadow_val_q;
            dots_d  = shadow_dot_q;
            err_d   = shadow_err_q;
        end

        // A commit on the threshold cycle wins: counter clears, stale stays low.
        if (commit) begin
            tmo_cnt_d = 24'd0;
            stale_d   = 1'b0;
        end else if (tmo_cnt_q != TMO_W) begin
            tmo_cnt_d = tmo_cnt_q + 24'd1;
            if (tmo_cnt_d == TMO_W) begin
                stale_d    = 1'b1;
                captured_d = 4'h0;
            end
        end

        if (commit) begin
            shadow_val_d[{dig_idx, 2'b00} +: 4] = dec[3:0];
            shadow_dot_d[dig_idx]               = hex_s2_q[7];
            shadow_err_d[dig_idx]               = dec[4];
            captured_d[dig_idx]                 = 1'b1;
        end
    end

    // State registers; reset discards any partial frame and the published one.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sel_s1_q     <= 4'h0;
            sel_s2_q     <= 4'h0;
            hex_s1_q     <= 8'h00;
            hex_s2_q     <= 8'h00;
            smp_prev_q   <= 12'h000;
            stab_cnt_q   <= 8'd0;
            shadow_val_q <= 16'h0000;
            shadow_dot_q <= 4'h0;
            shadow_err_q <= 4'h0;
            captured_q   <= 4'h0;
            tmo_cnt_q    <= 24'd0;
            stale_q      <= 1'b0;
            value_q      <= 16'h0000;
            dots_q       <= 4'h0;
            err_q        <= 4'h0;
            frame_vld_q  <= 1'b0;
        end else begin
            sel_s1_q     <= sel_s1_d;
            sel_s2_q     <= sel_s2_d;
            hex_s1_q     <= hex_s1_d;
            hex_s2_q     <= hex_s2_d;
            smp_prev_q   <= smp_prev_d;
            stab_cnt_q   <= stab_cnt_d;
            shadow_val_q <= shadow_val_d;
            shadow_dot_q <= shadow_dot_d;
            shadow_err_q <= shadow_err_d;
            captured_q   <= captured_d;
            tmo_cnt_q    <= tmo_cnt_d;
            stale_q      <= stale_d;
            value_q      <= value_d;
            dots_q       <= dots_d;
            err_q        <= err_d;
            frame_vld_q  <= frame_vld_d;
        end
    end

    assign VALUE_OUT       = value_q;
    assign DOTS_OUT        = dots_q;
    assign DIGIT_ERR_OUT   = err_q;
    assign FRAME_VALID_OUT = frame_vld_q;
    assign STALE_OUT       = stale_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Purpose : directed-vector bench for seg7_capture (STABLE_CYCLES=4, TIMEOUT_CYCLES=50).
// Latency : inputs change on the falling edge; outputs are sampled on the falling edge.
// Backpress: not applicable.
module tb_seg7_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 50;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  SEG_SELECT_IN;
    logic [7:0]  HEX_IN;
    logic [15:0] VALUE_OUT;
    logic [3:0]  DOTS_OUT;
    logic        FRAME_VALID_OUT;
    logic [3:0]  DIGIT_ERR_OUT;
    logic        STALE_OUT;

    int n_cmp     = 0;
    int n_bad     = 0;
    int pulse_cnt = 0;
    int base      = 0;

    seg7_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .SEG_SELECT_IN   (SEG_SELECT_IN),
        .HEX_IN          (HEX_IN),
        .VALUE_OUT       (VALUE_OUT),
        .DOTS_OUT        (DOTS_OUT),
        .FRAME_VALID_OUT (FRAME_VALID_OUT),
        .DIGIT_ERR_OUT   (DIGIT_ERR_OUT),
        .STALE_OUT       (STALE_OUT)
    );

    always #5 CLK = ~CLK;

    // Count frame pulses; each pulse is exactly one cycle wide.
    always @(negedge CLK) begin
        if (FRAME_VALID_OUT === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic show(input logic [3:0] sel, input logic [7:0] hex, input int cyc);
        SEG_SELECT_IN = sel;
        HEX_IN        = hex;
        repeat (cyc) @(negedge CLK);
    endtask

    task automatic idle(input int cyc);
        show(4'hF, 8'hFF, cyc);
    endtask

    initial begin
        RESET         = 1'b0;
        SEG_SELECT_IN = 4'hF;
        HEX_IN        = 8'hFF;
        repeat (3) @(negedge CLK);
        chk("rst_value", 32'(VALUE_OUT), 32'h0);
        chk("rst_dots",  32'(DOTS_OUT), 32'h0);
        chk("rst_fv",    32'(FRAME_VALID_OUT), 32'h0);
        chk("rst_err",   32'(DIGIT_ERR_OUT), 32'h0);
        chk("rst_stale", 32'(STALE_OUT), 32'h0);
        RESET = 1'b1;
        idle(3);

        // Basic scan: 3,5,E(dot),F
        base = pulse_cnt;
        show(4'b1110, 8'h30, 8);
        show(4'b1101, 8'h12, 8);
        show(4'b1011, 8'h86, 8);
        show(4'b0111, 8'h0E, 8);
        idle(4);
        chk("scan_value",  32'(VALUE_OUT), 32'hFE53);
        chk("scan_dots",   32'(DOTS_OUT), 32'h4);
        chk("scan_err",    32'(DIGIT_ERR_OUT), 32'h0);
        chk("scan_pulses", 32'(pulse_cnt - base), 32'd1);

        // Reset mid-frame: digits 0 and 1 committed, then discarded
        base = pulse_cnt;
        show(4'b1110, 8'h40, 8);
        show(4'b1101, 8'h79, 8);
        RESET = 1'b0;
        #1;
        chk("mid_rst_value", 32'(VALUE_OUT), 32'h0);
        chk("mid_rst_dots",  32'(DOTS_OUT), 32'h0);
        chk("mid_rst_fv",    32'(FRAME_VALID_OUT), 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        show(4'b1011, 8'h24, 8);
        show(4'b0111, 8'h19, 8);
        idle(2);
        chk("mid_rst_no_early_frame", 32'(pulse_cnt - base), 32'd0);
        show(4'b1110, 8'h02, 8);
        show(4'b1101, 8'h00, 8);
        idle(4);
        chk("post_rst_value",  32'(VALUE_OUT), 32'h4286);
        chk("post_rst_pulses", 32'(pulse_cnt - base), 32'd1);

        // Glitch: digit 0 shown only 3 cycles must not commit
        base = pulse_cnt;
        show(4'b1110, 8'h24, 3);
        show(4'b1101, 8'h79, 8);
        show(4'b1011, 8'h79, 8);
        show(4'b0111, 8'h79, 8);
        chk("glitch_no_frame", 32'(pulse_cnt - base), 32'd0);
        SEG_SELECT_IN = 4'b1110;
        HEX_IN        = 8'h79;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 6) chk("latency_pre", 32'(FRAME_VALID_OUT), 32'h0);
            if (k == 7) chk("latency_hit", 32'(FRAME_VALID_OUT), 32'h1);
        end
        idle(3);
        chk("glitch_value",  32'(VALUE_OUT), 32'h1111);
        chk("glitch_dots",   32'(DOTS_OUT), 32'h0);
        chk("glitch_pulses", 32'(pulse_cnt - base), 32'd1);

        // Illegal select (two digits low): no commit, timeout keeps counting
        base = pulse_cnt;
        show(4'b1100, 8'h40, 20);
        chk("illegal_no_frame", 32'(pulse_cnt - base), 32'd0);
        chk("illegal_not_stale", 32'(STALE_OUT), 32'h0);
        idle(40);
        chk("illegal_then_stale", 32'(STALE_OUT), 32'h1);
        chk("stale_keeps_value",  32'(VALUE_OUT), 32'h1111);

        // Undecodable pattern on digit 3
        base = pulse_cnt;
        show(4'b1110, 8'h40, 8);
        chk("commit_clears_stale", 32'(STALE_OUT), 32'h0);
        show(4'b1101, 8'h40, 8);
        show(4'b1011, 8'h40, 8);
        show(4'b0111, 8'h7F, 8);
        idle(4);
        chk("bad_value",  32'(VALUE_OUT), 32'h0000);
        chk("bad_err",    32'(DIGIT_ERR_OUT), 32'h8);
        chk("bad_dots",   32'(DOTS_OUT), 32'h0);
        chk("bad_pulses", 32'(pulse_cnt - base), 32'd1);

        // Timeout: digits 0-2 committed, then bus idle past the threshold
        base = pulse_cnt;
        show(4'b1110, 8'h30, 8);
        show(4'b1101, 8'h30, 8);
        show(4'b1011, 8'h30, 8);
        idle(47);
        chk("tmo_before", 32'(STALE_OUT), 32'h0);
        idle(1);
        chk("tmo_at",     32'(STALE_OUT), 32'h1);
        idle(12);
        chk("tmo_hold_value", 32'(VALUE_OUT), 32'h0000);
        chk("tmo_hold_err",   32'(DIGIT_ERR_OUT), 32'h8);
        show(4'b0111, 8'h30, 8);
        chk("tmo_cleared_by_commit", 32'(STALE_OUT), 32'h0);
        chk("tmo_partial_discarded", 32'(pulse_cnt - base), 32'd0);
        show(4'b1110, 8'h79, 8);
        show(4'b1101, 8'h79, 8);
        show(4'b1011, 8'h79, 8);
        idle(4);
        chk("tmo_refill_value",  32'(VALUE_OUT), 32'h3111);
        chk("tmo_refill_err",    32'(DIGIT_ERR_OUT), 32'h0);
        chk("tmo_refill_pulses", 32'(pulse_cnt - base), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
